// File: rtl/sik_fetch_stage.sv
// -----------------------------------------------------------------------------
// sik_fetch_stage
// Instruction-fetch front end of the SIK stack processor. Owns the PC, issues
// reads to a 1-cycle-latency instruction memory, folds `pre` prefix words into
// the following instruction and presents fetched instructions to decode through
// a 2-entry valid/ready buffer. Supports redirect (flush) and halt/drain.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   imem_rd / imem_addr          read strobe and address to instruction memory
//   imem_data                    read data, valid the cycle after imem_rd
//   redirect_valid / redirect_pc control-flow change from a later stage
//   halt_req                     stop fetching and drain
//   out_valid / out_ready        handshake with decode
//   out_inst / out_pc            instruction at buffer head and its address
//   out_pre_valid / out_pre      prefix attached to out_inst (0 when none)
//   halted                       fetch stopped and fully drained
// -----------------------------------------------------------------------------
module sik_fetch_stage #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = 16'h0000,
    parameter logic [3:0]       PRE_OP   = 4'hB
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_rd,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_inst,
    output logic [WIDTH-1:0] out_pc,
    output logic             out_pre_valid,
    output logic [3:0]       out_pre,
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] inst;
        logic [WIDTH-1:0] pc;
        logic             pre_valid;
        logic [3:0]       pre;
    } entry_t;

    localparam int unsigned      ENTRY_W = 2 * WIDTH + 5;
    localparam logic [WIDTH-1:0] PC_ONE  = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] PC_ZERO = {WIDTH{1'b0}};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic             pre_pending_q, pre_pending_d;
    logic [3:0]       pre_q, pre_d;
    logic [1:0]       count_q, count_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic             out_valid_q, out_valid_d;
    logic             halted_q, halted_d;

    logic             pop_s;
    logic             push_s;
    logic             resp_pre_s;
    logic             issue_s;
    logic [2:0]       occupancy_s;
    entry_t           new_entry_s;

    // Issue decision: a read goes out only if its result is guaranteed a slot.
    always_comb begin
        pop_s       = out_valid_q & out_ready;
        // Slots claimed after this cycle: buffered + in flight - leaving now.
        occupancy_s = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        if (!reset && !redirect_valid && !halt_req &&
            (state_q == ST_FETCH) && (occupancy_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        imem_rd   = issue_s;
        imem_addr = issue_s ? pc_q : PC_ZERO;
    end

    // Response classification and the buffer entry it would create.
    always_comb begin
        resp_pre_s            = inflight_q & (imem_data[WIDTH-1 -: 4] == PRE_OP);
        // A response landing in a redirect cycle belongs to the old path.
        push_s                = inflight_q & ~resp_pre_s & ~redirect_valid;
        new_entry_s.inst      = imem_data;
        new_entry_s.pc        = inflight_pc_q;
        new_entry_s.pre_valid = pre_pending_q;
        new_entry_s.pre       = pre_pending_q ? pre_q : 4'h0;
    end

    // PC, in-flight tracking and prefix folding.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue_s;
        inflight_pc_d = inflight_pc_q;
        pre_pending_d = pre_pending_q;
        pre_d         = pre_q;
        if (redirect_valid) begin
            pc_d          = redirect_pc;
            pre_pending_d = 1'b0;
        end else begin
            if (issue_s) begin
                pc_d          = pc_q + PC_ONE;
                inflight_pc_d = pc_q;
            end else begin
                pc_d = pc_q;
            end
            // Last prefix wins; a real instruction consumes it.
            if (resp_pre_s) begin
                pre_pending_d = 1'b1;
                pre_d         = imem_data[3:0];
            end else if (push_s) begin
                pre_pending_d = 1'b0;
            end else begin
                pre_pending_d = pre_pending_q;
            end
        end
    end

    // Two-entry buffer: head drives the outputs directly, tail backs it up.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirect_valid) begin
            head_d  = {ENTRY_W{1'b0}};
            tail_d  = {ENTRY_W{1'b0}};
            count_d = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d  = new_entry_s;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        tail_d  = new_entry_s;
                        count_d = 2'd2;
                    end else begin
                        // Full with no pop cannot coincide with a push.
                        count_d = count_q;
                    end
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_d  = tail_q;
                        tail_d  = {ENTRY_W{1'b0}};
                        count_d = 2'd1;
                    end else begin
                        head_d  = {ENTRY_W{1'b0}};
                        count_d = 2'd0;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = new_entry_s;
                    end else begin
                        head_d = new_entry_s;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        out_valid_d = (count_d != 2'd0);
    end

    // Fetch/drain/halt control; redirect flushes but never restarts fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (halt_req) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (count_q == 2'd0)) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_DRAIN;
            end
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= PC_RESET;
            inflight_pc_q <= PC_ZERO;
            inflight_q    <= 1'b0;
            pre_pending_q <= 1'b0;
            pre_q         <= 4'h0;
            count_q       <= 2'd0;
            head_q        <= {ENTRY_W{1'b0}};
            tail_q        <= {ENTRY_W{1'b0}};
            out_valid_q   <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            pre_pending_q <= pre_pending_d;
            pre_q         <= pre_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            out_valid_q   <= out_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_inst      = head_q.inst;
    assign out_pc        = head_q.pc;
    assign out_pre_valid = head_q.pre_valid;
    assign out_pre       = head_q.pre;
    assign halted        = halted_q;

endmodule

// File: tb/tb_sik_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_sik_fetch_stage
// Self-checking bench for sik_fetch_stage. A memory array answers reads one
// cycle late; a program-order reference model walks memory from the current
// start address, folds prefixes and yields the instruction stream decode must
// receive. Each scenario task drives stimulus and checks its own results.
// -----------------------------------------------------------------------------
module tb_sik_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_inst;
    logic [15:0] out_pc;
    logic        out_pre_valid;
    logic [3:0]  out_pre;
    logic        halted;

    int checks;
    int failures;

    logic [15:0] mem [0:65535];

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
        logic        pv;
        logic [3:0]  pre;
    } exp_t;

    // Reference model state: next address in program order and pending prefix.
    logic [15:0] m_pc;
    logic        m_pv;
    logic [3:0]  m_pre;

    sik_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_pre_valid  (out_pre_valid),
        .out_pre        (out_pre),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: 1-cycle latency, garbage when not read.
    always @(posedge clk) begin
        if (imem_rd === 1'b1) imem_data <= mem[imem_addr];
        else imem_data <= 16'($urandom);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Next instruction decode should see, by walking memory in program order.
    function automatic exp_t model_next();
        exp_t e;
        logic [15:0] w;
        logic done;
        e = '0;
        done = 1'b0;
        for (int k = 0; k < 256 && !done; k++) begin
            w = mem[m_pc];
            if (w[15:12] == 4'hB) begin
                m_pv  = 1'b1;
                m_pre = w[3:0];
            end else begin
                e.inst = w;
                e.pc   = m_pc;
                e.pv   = m_pv;
                e.pre  = m_pv ? m_pre : 4'h0;
                m_pv   = 1'b0;
                done   = 1'b1;
            end
            m_pc = m_pc + 16'd1;
        end
        return e;
    endfunction

    task automatic fill_mem(input int pre_pct);
        logic [15:0] w;
        for (int a = 0; a < 65536; a++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 99) < pre_pct) w[15:12] = 4'hB;
            else if (w[15:12] == 4'hB) w[15:12] = 4'hA;
            mem[a] = w;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0000; halt_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_pc = 16'h0000; m_pv = 1'b0; m_pre = 4'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h1234;
        halt_req = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({imem_rd, imem_addr, out_valid, out_inst, out_pc, out_pre_valid, out_pre, halted} !== 55'd0) begin
                failures++;
                $display("FAIL reset_outputs: got rd=%b addr=%h v=%b inst=%h pc=%h pv=%b pre=%h halted=%b, want all 0",
                         imem_rd, imem_addr, out_valid, out_inst, out_pc, out_pre_valid, out_pre, halted);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sequential();
        logic [15:0] seq [4];
        seq[0] = 16'h1001; seq[1] = 16'h2002; seq[2] = 16'h3003; seq[3] = 16'h4004;
        fill_mem(0);
        for (int i = 0; i < 4; i++) mem[i] = seq[i];
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (cyc < 4) begin
                checks++;
                if (imem_rd !== 1'b1 || imem_addr !== 16'(cyc)) begin
                    failures++;
                    $display("FAIL seq_issue c%0d: got rd=%b addr=%h, want rd=1 addr=%h", cyc, imem_rd, imem_addr, 16'(cyc));
                end
            end
            if (cyc < 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL seq_latency c%0d: got out_valid=%b, want 0", cyc, out_valid);
                end
            end else if (cyc < 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_inst !== seq[cyc-2] || out_pc !== 16'(cyc-2) || out_pre_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL seq_out c%0d: got v=%b inst=%h pc=%h pv=%b, want v=1 inst=%h pc=%h pv=0",
                             cyc, out_valid, out_inst, out_pc, out_pre_valid, seq[cyc-2], 16'(cyc-2));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_prefix(input logic dbl);
        exp_t e;
        exp_t got [$];
        fill_mem(0);
        if (dbl) begin
            mem[0] = 16'hB003; mem[1] = 16'hB005; mem[2] = 16'h2222;
        end else begin
            mem[0] = 16'hB00C; mem[1] = 16'h1234; mem[2] = 16'h5678;
        end
        do_reset();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                e = model_next();
                got.push_back({out_inst, out_pc, out_pre_valid, out_pre});
                checks++;
                if ({out_inst, out_pc, out_pre_valid, out_pre} !== e) begin
                    failures++;
                    $display("FAIL prefix_stream: got inst=%h pc=%h pv=%b pre=%h, want inst=%h pc=%h pv=%b pre=%h",
                             out_inst, out_pc, out_pre_valid, out_pre, e.inst, e.pc, e.pv, e.pre);
                end
                if (dbl) begin
                    checks++;
                    if (out_pre_valid === 1'b1 && out_pre === 4'h3) begin
                        failures++;
                        $display("FAIL prefix_overwrite: got pre=3 on inst=%h, want 3 never to appear", out_inst);
                    end
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (got.size() < 2) begin
            failures++;
            $display("FAIL prefix_count: got %0d outputs, want at least 2", got.size());
        end else if (dbl) begin
            if (got[0] !== {16'h2222, 16'h0002, 1'b1, 4'h5}) begin
                failures++;
                $display("FAIL prefix_last_wins: got %h, want inst=2222 pc=0002 pv=1 pre=5", got[0]);
            end
        end else begin
            if (got[0] !== {16'h1234, 16'h0001, 1'b1, 4'hC} || got[1].pv !== 1'b0) begin
                failures++;
                $display("FAIL prefix_attach: got first=%h second_pv=%b, want inst=1234 pc=0001 pv=1 pre=C then pv=0",
                         got[0], got[1].pv);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [15:0] held;
        fill_mem(0);
        do_reset();
        held = 16'h0000;
        for (int cyc = 0; cyc < 25; cyc++) begin
            out_ready = !(cyc >= 8 && cyc < 13);
            @(negedge clk);
            if (cyc == 8) held = out_inst;
            if (cyc >= 8 && cyc < 13) begin
                checks++;
                if (imem_rd !== 1'b0 || out_valid !== 1'b1 || out_inst !== held) begin
                    failures++;
                    $display("FAIL stall c%0d: got rd=%b v=%b inst=%h, want rd=0 v=1 inst=%h", cyc, imem_rd, out_valid, out_inst, held);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                e = model_next();
                checks++;
                if ({out_inst, out_pc, out_pre_valid, out_pre} !== e) begin
                    failures++;
                    $display("FAIL stall_stream: got inst=%h pc=%h, want inst=%h pc=%h", out_inst, out_pc, e.inst, e.pc);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        exp_t first;
        logic seen;
        fill_mem(0);
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'hB007; mem[3] = 16'h3333;
        mem[16'h0040] = 16'h4040;
        do_reset();
        for (int cyc = 0; cyc < 8; cyc++) begin
            out_ready = (cyc == 4);
            redirect_valid = (cyc == 7);
            redirect_pc = 16'h0040;
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready) begin
                e = model_next();
                checks++;
                if ({out_inst, out_pc, out_pre_valid, out_pre} !== e) begin
                    failures++;
                    $display("FAIL redir_pre_stream: got inst=%h pc=%h, want inst=%h pc=%h", out_inst, out_pc, e.inst, e.pc);
                end
            end
            @(posedge clk); #1;
        end
        m_pc = 16'h0040; m_pv = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        first = '0;
        for (int cyc = 8; cyc < 20; cyc++) begin
            @(negedge clk);
            if (cyc == 8) begin
                checks++;
                if (out_valid !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 16'h0040) begin
                    failures++;
                    $display("FAIL redir_restart: got v=%b rd=%b addr=%h, want v=0 rd=1 addr=0040", out_valid, imem_rd, imem_addr);
                end
            end
            if (out_valid === 1'b1) begin
                if (!seen) first = {out_inst, out_pc, out_pre_valid, out_pre};
                seen = 1'b1;
                e = model_next();
                checks++;
                if ({out_inst, out_pc, out_pre_valid, out_pre} !== e) begin
                    failures++;
                    $display("FAIL redir_stream: got inst=%h pc=%h pv=%b, want inst=%h pc=%h pv=%b",
                             out_inst, out_pc, out_pre_valid, e.inst, e.pc, e.pv);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (first !== {16'h4040, 16'h0040, 1'b0, 4'h0}) begin
            failures++;
            $display("FAIL redir_first: got %h, want inst=4040 pc=0040 pv=0 pre=0", first);
        end
    endtask

    // Random program, random backpressure and random redirects; also used
    // for the wrap-around run by starting just below 16'hFFFF.
    task automatic test_random(input int cycles, input int redir_pct, input logic wrap);
        exp_t e;
        logic [15:0] exp_issue;
        logic prev_redir, prev_stall;
        logic [36:0] prev_out;
        fill_mem(25);
        do_reset();
        exp_issue = 16'h0000; prev_redir = 1'b0; prev_stall = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            out_ready = wrap ? 1'b1 : ($urandom_range(0, 99) < 70);
            redirect_valid = wrap ? (cyc == 0) : ((cyc > 3) && ($urandom_range(0, 99) < redir_pct));
            redirect_pc = wrap ? 16'hFFFD : 16'($urandom_range(0, 16'h3000));
            @(negedge clk);
            if (prev_redir) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_flush c%0d: got out_valid=%b after redirect, want 0", cyc, out_valid);
                end
            end
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || {out_inst, out_pc, out_pre_valid, out_pre} !== prev_out) begin
                    failures++;
                    $display("FAIL rnd_hold c%0d: got v=%b inst=%h pc=%h, want held %h", cyc, out_valid, out_inst, out_pc, prev_out);
                end
            end
            if (redirect_valid) begin
                checks++;
                if (imem_rd !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_redir_issue c%0d: got imem_rd=%b in redirect cycle, want 0", cyc, imem_rd);
                end
            end else if (imem_rd === 1'b1) begin
                checks++;
                if (imem_addr !== exp_issue) begin
                    failures++;
                    $display("FAIL rnd_issue_addr c%0d: got %h, want %h", cyc, imem_addr, exp_issue);
                end
                exp_issue = exp_issue + 16'd1;
            end
            if (out_valid === 1'b1 && out_ready) begin
                e = model_next();
                checks++;
                if ({out_inst, out_pc, out_pre_valid, out_pre} !== e) begin
                    failures++;
                    $display("FAIL rnd_stream c%0d: got inst=%h pc=%h pv=%b pre=%h, want inst=%h pc=%h pv=%b pre=%h",
                             cyc, out_inst, out_pc, out_pre_valid, out_pre, e.inst, e.pc, e.pv, e.pre);
                end
            end else if (out_valid !== 1'b1) begin
                checks++;
                if (out_valid !== 1'b0 || {out_inst, out_pc, out_pre_valid, out_pre} !== 37'd0) begin
                    failures++;
                    $display("FAIL rnd_idle c%0d: got v=%b inst=%h pc=%h pv=%b pre=%h, want all 0",
                             cyc, out_valid, out_inst, out_pc, out_pre_valid, out_pre);
                end
            end
            if (redirect_valid) begin
                m_pc = redirect_pc; m_pv = 1'b0; exp_issue = redirect_pc;
            end
            prev_redir = redirect_valid;
            prev_stall = (out_valid === 1'b1) && !out_ready && !redirect_valid;
            prev_out = {out_inst, out_pc, out_pre_valid, out_pre};
            @(posedge clk); #1;
        end
        redirect_valid = 1'b0;
        if (wrap) begin
            checks++;
            if (m_pc > 16'h0010 || m_pc < 16'h0002) begin
                failures++;
                $display("FAIL wrap_progress: got model pc=%h after run, want it wrapped past 0000", m_pc);
            end
        end
    endtask

    task automatic test_halt();
        exp_t e;
        int transfers;
        fill_mem(0);
        do_reset();
        out_ready = 1'b1;
        transfers = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            halt_req = (cyc == 5);
            @(negedge clk);
            checks++;
            if (cyc < 5) begin
                if (imem_rd !== 1'b1 || imem_addr !== 16'(cyc)) begin
                    failures++;
                    $display("FAIL halt_issue c%0d: got rd=%b addr=%h, want rd=1 addr=%h", cyc, imem_rd, imem_addr, 16'(cyc));
                end
            end else if (imem_rd !== 1'b0) begin
                failures++;
                $display("FAIL halt_no_issue c%0d: got imem_rd=%b, want 0", cyc, imem_rd);
            end
            if (halted === 1'b1 && out_valid === 1'b1) begin
                checks++; failures++;
                $display("FAIL halt_early c%0d: got halted=1 with out_valid=1, want halted only when drained", cyc);
            end
            if (out_valid === 1'b1) begin
                e = model_next();
                transfers++;
                checks++;
                if ({out_inst, out_pc, out_pre_valid, out_pre} !== e) begin
                    failures++;
                    $display("FAIL halt_stream: got inst=%h pc=%h, want inst=%h pc=%h", out_inst, out_pc, e.inst, e.pc);
                end
            end
            @(posedge clk); #1;
        end
        halt_req = 1'b0;
        checks++;
        if (transfers != 5 || halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_drain: got transfers=%0d halted=%b, want 5 and 1", transfers, halted);
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0020;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || imem_rd !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL halt_redirect c%0d: got halted=%b rd=%b v=%b, want 1 0 0", cyc, halted, imem_rd, out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0000; halt_req = 1'b0;
        test_reset();
        test_sequential();
        test_prefix(1'b0);
        test_prefix(1'b1);
        test_backpressure();
        test_redirect();
        test_random(600, 4, 1'b0);
        test_random(14, 0, 1'b1);
        test_halt();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
